// File: rtl/key_press_decoder.sv
// key_press_decoder: classifies debounced press/release pulses into short, double, long, repeat and long-release events
module key_press_decoder #(
  parameter int N          = 32,
  parameter int LONG_CYC   = 100_000_000,
  parameter int DCLK_CYC   = 30_000_000,
  parameter int REPEAT_CYC = 10_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic button_negedge,
  input  logic button_posedge,
  output logic short_press,
  output logic double_click,
  output logic long_press,
  output logic long_repeat,
  output logic long_release,
  output logic busy
);
  typedef enum logic [2:0] {IDLE, PRESS1, LONG_HOLD, WAIT2, PRESS2} state_t;
  state_t state, state_nx;
  logic [N-1:0] timer, timer_nx;
  logic short_nx, double_nx, long_nx, repeat_nx, long_rel_nx;
  logic long_tc, dclk_tc, rep_tc;
  assign long_tc = timer == N'(LONG_CYC - 1);
  assign dclk_tc = timer == N'(DCLK_CYC - 1);
  assign rep_tc  = timer == N'(REPEAT_CYC - 1);
  // state, timer and registered event outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      timer        <= '0;
      short_press  <= 1'b0;
      double_click <= 1'b0;
      long_press   <= 1'b0;
      long_repeat  <= 1'b0;
      long_release <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state        <= state_nx;
      timer        <= timer_nx;
      short_press  <= short_nx;
      double_click <= double_nx;
      long_press   <= long_nx;
      long_repeat  <= repeat_nx;
      long_release <= long_rel_nx;
      busy         <= state_nx != IDLE;
    end
  end
  // next state; release beats long count, press beats double-click timeout
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:      state_nx = button_negedge ? PRESS1 : IDLE;
      PRESS1:    state_nx = button_posedge ? WAIT2 : long_tc ? LONG_HOLD : PRESS1;
      LONG_HOLD: state_nx = button_posedge ? IDLE : LONG_HOLD;
      WAIT2:     state_nx = button_negedge ? PRESS2 : dclk_tc ? IDLE : WAIT2;
      PRESS2:    state_nx = button_posedge ? IDLE : PRESS2;
      default:   state_nx = IDLE;
    endcase
    timer_nx = (state_nx != state || state == IDLE || state == PRESS2 ||
                (state == LONG_HOLD && rep_tc)) ? '0 : timer + 1'b1;
  end
  // event pulses decided from current state and sampled inputs
  always_comb begin
    short_nx    = state == WAIT2 && !button_negedge && dclk_tc;
    double_nx   = state == PRESS2 && button_posedge;
    long_nx     = state == PRESS1 && !button_posedge && long_tc;
    repeat_nx   = state == LONG_HOLD && !button_posedge && rep_tc;
    long_rel_nx = state == LONG_HOLD && button_posedge;
  end
endmodule
